tcam_rule_writer: RTL and testbench

- Update engine for the SRAM-based TCAM: writes one ternary rule (value/mask) into, or deletes it from, the SRAM sub-blocks that the BPT search path reads.
- The W-bit rule is split into S = W/B slices. Slice i (value bits [i*B +: B]) owns sub-block i, which has 2^B rows of N columns; column k belongs to rule k.
- The writer sweeps every row address once and updates only the target rule's column through a per-bit write enable, so no read-modify-write is needed.

---
 rtl/tcam_pkg.sv | 29 ++
 rtl/tcam_row_gen.sv | 28 ++
 rtl/tcam_rule_writer.sv | 106 ++++++++++
 tb/tb_tcam_rule_writer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared constants, types and the per-slice match rule for the SRAM-based TCAM.
// Used by the rule writer and by the search-side model.
package tcam_pkg;

    localparam int unsigned W   = 16;
    localparam int unsigned B   = 8;
    localparam int unsigned N   = 32;
    localparam int unsigned S   = W / B;
    localparam int unsigned IDW = $clog2(N);

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_e;

    // Writer states
    typedef logic [1:0] wr_state_t;
    localparam wr_state_t IDLE  = 2'd0;
    localparam wr_state_t SWEEP = 2'd1;
    localparam wr_state_t DONE  = 2'd2;

    // A row address matches a slice when every cared-about bit agrees.
    function automatic logic slice_match(input logic [B-1:0] addr,
                                         input logic [B-1:0] value_slice,
                                         input logic [B-1:0] mask_slice);
        return ((addr ^ value_slice) & ~mask_slice) == '0;
    endfunction

endpackage

// File: rtl/tcam_row_gen.sv
// Combinational row generator: the write data for every sub-block and the shared
// per-bit enable for one row of the sweep.
module tcam_row_gen
    import tcam_pkg::*;
(
    input  logic             active,
    input  logic [B-1:0]     addr,
    input  op_e              op,
    input  logic [IDW-1:0]   id,
    input  logic [W-1:0]     value,
    input  logic [W-1:0]     mask,
    output logic [S*N-1:0]   wdata,
    output logic [N-1:0]     wbe
);

    always_comb begin
        wbe   = '0;
        wdata = '0;
        if (active) begin
            wbe[id] = 1'b1;
            for (int i = 0; i < S; i++) begin
                wdata[i*N + int'(id)] = (op == OP_INSERT) &&
                    slice_match(addr, value[i*B +: B], mask[i*B +: B]);
            end
        end
    end

endmodule

// File: rtl/tcam_rule_writer.sv
// TCAM rule update engine: sweeps all 2^B rows once, writing only the target
// rule's column in every sub-block.
module tcam_rule_writer
    import tcam_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [IDW-1:0]   req_id,
    input  logic [W-1:0]     req_value,
    input  logic [W-1:0]     req_mask,
    output logic [S-1:0]     mem_we,
    output logic [B-1:0]     mem_addr,
    output logic [S*N-1:0]   mem_wdata,
    output logic [N-1:0]     mem_wbe,
    output logic             busy,
    output logic             done
);

    localparam logic [B:0] LAST_ROW = {1'b0, {B{1'b1}}};

    wr_state_t      state_q, state_d;
    // One extra bit so the terminal count never aliases with row 0.
    logic [B:0]     cnt_q, cnt_d;
    logic [B-1:0]   addr_q, addr_d;
    op_e            op_q, op_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   value_q, value_d;
    logic [W-1:0]   mask_q, mask_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_d    = op_q;
        id_d    = id_q;
        value_d = value_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = op_e'(req_op);
                    id_d    = req_id;
                    value_d = req_value;
                    mask_d  = req_mask;
                    cnt_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                cnt_d  = cnt_q + 1'b1;
                addr_d = cnt_q[B-1:0];
                if (cnt_q == LAST_ROW) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= OP_INSERT;
            id_q    <= '0;
            value_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            id_q    <= id_d;
            value_q <= value_d;
            mask_q  <= mask_d;
        end
    end

    logic sweeping;

    always_comb begin
        sweeping  = (state_q == SWEEP);
        req_ready = (state_q == IDLE);
        busy      = sweeping;
        done      = (state_q == DONE);
        mem_we    = sweeping ? {S{1'b1}} : '0;
        mem_addr  = sweeping ? cnt_q[B-1:0] : addr_q;
    end

    tcam_row_gen u_row_gen (
        .active (sweeping),
        .addr   (cnt_q[B-1:0]),
        .op     (op_q),
        .id     (id_q),
        .value  (value_q),
        .mask   (mask_q),
        .wdata  (mem_wdata),
        .wbe    (mem_wbe)
    );

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Scoreboard bench for tcam_rule_writer: directed requests push expected rows,
// a negedge monitor pops and compares every presented row and done pulse.
module tb_tcam_rule_writer;
    import tcam_pkg::*;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [IDW-1:0]   req_id;
    logic [W-1:0]     req_value;
    logic [W-1:0]     req_mask;
    logic [S-1:0]     mem_we;
    logic [B-1:0]     mem_addr;
    logic [S*N-1:0]   mem_wdata;
    logic [N-1:0]     mem_wbe;
    logic             busy;
    logic             done;

    tcam_rule_writer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_id    (req_id),
        .req_value (req_value),
        .req_mask  (req_mask),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wbe   (mem_wbe),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic           op;
        logic [4:0]     id;
        logic [15:0]    value;
        logic [15:0]    mask;
        int             s0lo, s0hi, s1lo, s1hi;  // hand-derived matching row ranges
    } vec_t;

    typedef struct {
        int unsigned    cyc;
        logic [7:0]     addr;
        logic [63:0]    wdata;
        logic [31:0]    wbe;
    } row_t;

    row_t        rows_q[$];
    int unsigned done_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 128'(req_ready), 128'(1));
        chk({tag, "_busy"},  128'(busy), 128'(0));
        chk({tag, "_done"},  128'(done), 128'(0));
        chk({tag, "_we"},    128'(mem_we), 128'(0));
        chk({tag, "_addr"},  128'(mem_addr), 128'(0));
        chk({tag, "_wdata"}, 128'(mem_wdata), 128'(0));
        chk({tag, "_wbe"},   128'(mem_wbe), 128'(0));
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we != '0) begin
                row_t r;
                chk("row_we", 128'(mem_we), 128'(2'b11));
                chk("row_busy_ready", 128'({busy, req_ready}), 128'(2'b10));
                if (rows_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_row: got addr %0h expected no row", mem_addr);
                end else begin
                    r = rows_q.pop_front();
                    chk("row_addr",  128'(mem_addr), 128'(r.addr));
                    chk("row_wdata", 128'(mem_wdata), 128'(r.wdata));
                    chk("row_wbe",   128'(mem_wbe), 128'(r.wbe));
                    chk("row_cycle", 128'(edge_cnt), 128'(r.cyc));
                end
            end else begin
                chk("idle_data_wbe", {32'(0), mem_wbe, mem_wdata}, 128'(0));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected done=0");
                end else begin
                    chk("done_cycle", 128'(edge_cnt), 128'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic issue(input vec_t v, output int unsigned t0);
        int n;
        @(negedge clk);
        req_op    = v.op;
        req_id    = v.id;
        req_value = v.value;
        req_mask  = v.mask;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                $display("FAIL accept_timeout: got no accept expected accept within 1000 cycles");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        t0 = edge_cnt;
        for (int a = 0; a < 256; a++) begin
            row_t r;
            r.cyc   = t0 + a;
            r.addr  = 8'(a);
            r.wbe   = 32'd1 << v.id;
            r.wdata = '0;
            if (v.op == 1'b0) begin
                if (a >= v.s0lo && a <= v.s0hi) r.wdata[v.id] = 1'b1;
                if (a >= v.s1lo && a <= v.s1hi) r.wdata[32 + int'(v.id)] = 1'b1;
            end
            rows_q.push_back(r);
        end
        done_q.push_back(t0 + 256);
        // Latched copy must be used from here on.
        req_valid = 1'b0;
        req_value = 16'hffff;
        req_mask  = 16'h5a5a;
        req_id    = ~v.id;
        req_op    = ~v.op;
    endtask

    vec_t vecs[5];
    int unsigned t0, t_del, t_next;
    int n;

    initial begin
        vecs[0] = '{1'b0, 5'd3,  16'h0010, 16'h0000, 8'h10, 8'h10, 0, 0};
        vecs[1] = '{1'b0, 5'd0,  16'h008a, 16'h000f, 8'h80, 8'h8f, 0, 0};
        vecs[2] = '{1'b0, 5'd31, 16'h00fb, 16'hff00, 8'hfb, 8'hfb, 0, 255};
        vecs[3] = '{1'b1, 5'd5,  16'h1234, 16'h0000, 1, 0, 1, 0};
        vecs[4] = '{1'b0, 5'd7,  16'h4c21, 16'h0300, 8'h21, 8'h21, 8'h4c, 8'h4f};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_id    = '0;
        req_value = '0;
        req_mask  = '0;
        #1;
        chk_reset_outputs("rst_init");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(vecs[0], t0);
        issue(vecs[1], t0);
        issue(vecs[2], t0);
        issue(vecs[3], t_del);
        while (edge_cnt < t_del + 8) @(negedge clk);
        issue(vecs[4], t_next);
        chk("held_req_accept_edge", 128'(t_next), 128'(t_del + 258));

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((mem_addr != 8'h40 || !busy) && n < 400);
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL wait_addr40: got no row 40 expected row 40 within 400 cycles");
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        rows_q.delete();
        done_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 128'(req_ready), 128'(1));

        issue(vecs[4], t0);
        n = 0;
        while (done_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rows_left", 128'(rows_q.size()), 128'(0));
        chk("dones_left", 128'(done_q.size()), 128'(0));
        chk("final_ready", 128'(req_ready), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
